// File: rtl/mdu_sequencer.sv
// ---------------------------------------------------------------------------
// mdu_sequencer
//   Multi-cycle multiply/divide sequencer that sits beside the execute stage.
//   It accepts MULT/MULTU/DIV/DIVU and iterates one bit per cycle: shift-add
//   for multiply, restoring shift-subtract for divide. It owns HI/LO and
//   stalls the pipeline when a HI/LO access or a new op hits a busy unit.
//
//   Timeline for one op (edge 0 = edge where start is sampled in IDLE):
//     edge 0          : operands latched as magnitudes, state -> MUL/DIV
//     edges 1..WIDTH  : one iteration per edge, last one moves to FIX
//     edge WIDTH+1    : sign fix applied, HI/LO written, done pulses next cycle
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   start, op, a, b  op request (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   flush            abort any in-flight op, drop a same-cycle start
//   hilo_rd          MFHI/MFLO in execute (only affects stall)
//   wr_hi, wr_lo,    MTHI/MTLO write strobes and data, honoured only in IDLE
//   wr_data
//   busy             state != IDLE
//   stall            busy & (hilo_rd | wr_hi | wr_lo | start)
//   done             one-cycle pulse, HI/LO already hold the result
//   hi, lo           HI/LO registers
//
// Build option
//   MDU_EARLY_OUT_EN : multiply leaves the iteration loop as soon as the
//                      remaining multiplier bits are all zero.
// ---------------------------------------------------------------------------
module mdu_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hilo_rd,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StFix
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    // MUL: running product. DIV: {partial remainder, dividend/quotient}.
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    // MUL: left-shifting multiplicand. DIV: divisor in the low half.
    logic [2*WIDTH-1:0]   opd_q, opd_d;
    logic [WIDTH-1:0]     mpl_q, mpl_d;
    logic                 is_div_q, is_div_d;
    logic                 bz_q, bz_d;       // divisor was zero
    logic                 neg_lo_q, neg_lo_d; // negate product / quotient
    logic                 neg_hi_q, neg_hi_d; // negate remainder
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    // Combinational helpers
    logic                 signed_op;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2*WIDTH:0]     div_shift;
    logic [WIDTH+1:0]     div_trial;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo, rem;
    logic                 mul_last;

    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & a[WIDTH-1];
        b_neg     = signed_op & b[WIDTH-1];
        a_mag     = a_neg ? (~a + 1'b1) : a;
        b_mag     = b_neg ? (~b + 1'b1) : b;

        // Restoring step: shift {rem, dividend} left, trial-subtract divisor
        // from the upper WIDTH+1 bits; the extra MSB of div_trial is the borrow.
        div_shift = {acc_q, 1'b0};
        div_trial = {1'b0, div_shift[2*WIDTH:WIDTH]} - {2'b00, opd_q[WIDTH-1:0]};

        prod_fix  = neg_lo_q ? (~acc_q + 1'b1) : acc_q;
        quo       = acc_q[WIDTH-1:0];
        rem       = acc_q[2*WIDTH-1:WIDTH];

`ifdef MDU_EARLY_OUT_EN
        mul_last  = (cnt_q == '0) || ((mpl_q >> 1) == '0);
`else
        mul_last  = (cnt_q == '0);
`endif
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opd_d    = opd_q;
        mpl_d    = mpl_q;
        is_div_d = is_div_q;
        bz_d     = bz_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (wr_hi) hi_d = wr_data;
                if (wr_lo) lo_d = wr_data;
                if (start && !flush) begin
                    cnt_d    = CW'(WIDTH - 1);
                    is_div_d = op[1];
                    bz_d     = (b == '0);
                    neg_hi_d = a_neg;
                    // Divide by zero keeps the all-ones quotient unsigned.
                    neg_lo_d = (a_neg ^ b_neg) & ~(op[1] & (b == '0));
                    if (op[1]) begin
                        acc_d   = {{WIDTH{1'b0}}, a_mag};
                        opd_d   = {{WIDTH{1'b0}}, b_mag};
                        mpl_d   = '0;
                        state_d = StDiv;
                    end else begin
                        acc_d   = '0;
                        opd_d   = {{WIDTH{1'b0}}, a_mag};
                        mpl_d   = b_mag;
                        state_d = StMul;
                    end
                end
            end

            StMul: begin
                if (mpl_q[0]) acc_d = acc_q + opd_q;
                opd_d = opd_q << 1;
                mpl_d = mpl_q >> 1;
                cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
                if (mul_last) state_d = StFix;
            end

            StDiv: begin
                if (!div_trial[WIDTH+1]) begin
                    acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {div_shift[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
                if (cnt_q == '0) state_d = StFix;
            end

            StFix: begin
                if (is_div_q) begin
                    lo_d = bz_q ? {WIDTH{1'b1}} : (neg_lo_q ? (~quo + 1'b1) : quo);
                    hi_d = neg_hi_q ? (~rem + 1'b1) : rem;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                cnt_d   = '0;
                done_d  = 1'b1;
                state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase

        // Squash: HI/LO keep their old contents and done never fires.
        if (flush && (state_q != StIdle)) begin
            state_d = StIdle;
            cnt_d   = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            opd_q    <= '0;
            mpl_q    <= '0;
            is_div_q <= 1'b0;
            bz_q     <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opd_q    <= opd_d;
            mpl_q    <= mpl_d;
            is_div_q <= is_div_d;
            bz_q     <= bz_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy  = (state_q != StIdle);
    assign stall = busy & (hilo_rd | wr_hi | wr_lo | start);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
